// File: rtl/main_bus_unit.sv
// main_bus_unit
// Execution-side consumer of the Stage 2 control word. The unit holds
// general registers A-D, the PC/RA pair (one of them is the active program
// counter, chosen by the flip state), and the stack pointer. It drives the
// main bus, runs the memory request/acknowledge handshake for bus words,
// stalls the pipeline while memory is busy, and keeps the halt state.
//
// Ports
//   ClockIn    : system clock, rising edge
//   ResetIn    : asynchronous active-high reset
//   CtrlIn     : control word [3:0] MainAssert, [7:4] MainLoad, [9:8] Inc,
//                [12:10] Addr, [13] BusRequest, [14] PCRA_Flip, [15] Break
//   ConstIn    : immediate byte
//   AluIn      : ALU result byte
//   MemDataIn  : memory read data, valid with MemAck
//   MemAck     : memory completion strobe
//   ResumeIn   : clears the halt state
//   MemReq     : registered memory request
//   MemWrite   : registered write flag (1 = write)
//   MemAddr    : registered memory address
//   MemDataOut : registered write data
//   MainBus    : combinational main bus value
//   Stall      : upstream must hold CtrlIn, ConstIn and AluIn
//   PcraFlip   : flip state (selects RA as the active PC when 1)
//   Halted     : halt state
//   PcOut      : active program counter
//   SpOut      : stack pointer
module main_bus_unit #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              ClockIn,
  input  logic              ResetIn,
  input  logic [15:0]       CtrlIn,
  input  logic [DATA_W-1:0] ConstIn,
  input  logic [DATA_W-1:0] AluIn,
  input  logic [DATA_W-1:0] MemDataIn,
  input  logic              MemAck,
  input  logic              ResumeIn,
  output logic              MemReq,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataOut,
  output logic [DATA_W-1:0] MainBus,
  output logic              Stall,
  output logic              PcraFlip,
  output logic              Halted,
  output logic [ADDR_W-1:0] PcOut,
  output logic [ADDR_W-1:0] SpOut
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [3:0] main_assert;
  logic [3:0] main_load;
  logic [1:0] inc_sel;
  logic [2:0] addr_sel;
  logic       bus_request;
  logic       flip_req;
  logic       break_req;

  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;
  logic [DATA_W-1:0] reg_c;
  logic [DATA_W-1:0] reg_d;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] sp;
  logic [DATA_W-1:0] read_latch;

  logic [ADDR_W-1:0] active_pc;
  logic [ADDR_W-1:0] inactive_pc;
  logic [ADDR_W-1:0] pc_upd;
  logic [ADDR_W-1:0] addr_value;
  logic              commit;

  assign main_assert = CtrlIn[3:0];
  assign main_load   = CtrlIn[7:4];
  assign inc_sel     = CtrlIn[9:8];
  assign addr_sel    = CtrlIn[12:10];
  assign bus_request = CtrlIn[13];
  assign flip_req    = CtrlIn[14];
  assign break_req   = CtrlIn[15];

  assign active_pc   = PcraFlip ? ra : pc;
  assign inactive_pc = PcraFlip ? pc : ra;
  assign PcOut       = active_pc;
  assign SpOut       = sp;

  // A word commits either immediately (plain word in IDLE) or at the end of
  // its memory transfer (DONE). Nothing commits while halted.
  assign commit = !Halted &&
                  (((state == IDLE) && !bus_request) || (state == DONE));

  // Stall covers a bus word waiting to launch, the whole REQ wait, and the
  // halt state; DONE releases the pipeline because the word commits there.
  assign Stall = Halted || (state == REQ) || ((state == IDLE) && bus_request);

  // Main bus source; the read latch is only exposed in DONE so a stale read
  // value can never leak into a later word.
  always_comb begin
    MainBus = '0;
    case (main_assert)
      4'd1:    MainBus = reg_a;
      4'd2:    MainBus = reg_b;
      4'd3:    MainBus = reg_c;
      4'd4:    MainBus = reg_d;
      4'd5:    MainBus = ConstIn;
      4'd6:    MainBus = (state == DONE) ? read_latch : '0;
      4'd7:    MainBus = AluIn;
      default: MainBus = '0;
    endcase
  end

  // Address source, always from pre-commit state.
  always_comb begin
    addr_value = '0;
    case (addr_sel)
      3'd0:    addr_value = active_pc;
      3'd1:    addr_value = inactive_pc;
      3'd2:    addr_value = sp;
      3'd3:    addr_value = {reg_a, reg_b};
      3'd4:    addr_value = {reg_c, reg_d};
      default: addr_value = '0;
    endcase
  end

  // Active PC update: increment first, then a byte load overrides its half
  // so the other half keeps the incremented value.
  always_comb begin
    pc_upd = active_pc;
    if (inc_sel == 2'd1) pc_upd = active_pc + ADDR_W'(1);
    if (main_load == 4'd6) pc_upd[DATA_W-1:0] = MainBus;
    if (main_load == 4'd7) pc_upd[ADDR_W-1:DATA_W] = MainBus;
  end

  // Bus FSM next state. A bus word only launches when not halted; MemAck is
  // only honoured in REQ.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus_request && !Halted) state_next = REQ;
      REQ:     if (MemAck) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and memory interface registers. Reset drops MemReq
  // asynchronously, abandoning any transfer in flight.
  always_ff @(posedge ClockIn or posedge ResetIn) begin
    if (ResetIn) begin
      state      <= IDLE;
      MemReq     <= 1'b0;
      MemWrite   <= 1'b0;
      MemAddr    <= '0;
      MemDataOut <= '0;
      read_latch <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus_request && !Halted) begin
            MemReq     <= 1'b1;
            MemAddr    <= addr_value;
            MemWrite   <= (main_load == 4'd5);
            MemDataOut <= MainBus;
          end
        end
        REQ: begin
          if (MemAck) begin
            read_latch <= MemDataIn;
            MemReq     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Architectural state: every load, increment, flip and break lands on the
  // single commit edge. Resume only acts while halted.
  always_ff @(posedge ClockIn or posedge ResetIn) begin
    if (ResetIn) begin
      reg_a    <= '0;
      reg_b    <= '0;
      reg_c    <= '0;
      reg_d    <= '0;
      pc       <= '0;
      ra       <= '0;
      sp       <= '1;
      PcraFlip <= 1'b0;
      Halted   <= 1'b0;
    end else begin
      if (Halted) begin
        if (ResumeIn) Halted <= 1'b0;
      end else if (commit) begin
        case (main_load)
          4'd1:    reg_a <= MainBus;
          4'd2:    reg_b <= MainBus;
          4'd3:    reg_c <= MainBus;
          4'd4:    reg_d <= MainBus;
          default: ;
        endcase
        if (PcraFlip) ra <= pc_upd;
        else          pc <= pc_upd;
        if (inc_sel == 2'd2) sp <= sp + ADDR_W'(1);
        if (inc_sel == 2'd3) sp <= sp - ADDR_W'(1);
        if (flip_req)  PcraFlip <= ~PcraFlip;
        if (break_req) Halted   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_main_bus_unit.sv
// Testbench for main_bus_unit: directed scenarios plus a randomized word
// stream checked against an array-based reference model of the machine.
module tb_main_bus_unit;

  logic        ClockIn;
  logic        ResetIn;
  logic [15:0] CtrlIn;
  logic [7:0]  ConstIn;
  logic [7:0]  AluIn;
  logic [7:0]  MemDataIn;
  logic        MemAck;
  logic        ResumeIn;
  logic        MemReq;
  logic        MemWrite;
  logic [15:0] MemAddr;
  logic [7:0]  MemDataOut;
  logic [7:0]  MainBus;
  logic        Stall;
  logic        PcraFlip;
  logic        Halted;
  logic [15:0] PcOut;
  logic [15:0] SpOut;

  int tests_run;
  int tests_failed;

  // Reference model state
  logic [7:0]  m_reg [4];
  logic [15:0] m_pc  [2];
  logic [15:0] m_sp;
  logic        m_flip;
  logic        m_halt;

  logic        seen_stall;

  main_bus_unit dut (
    .ClockIn(ClockIn), .ResetIn(ResetIn), .CtrlIn(CtrlIn), .ConstIn(ConstIn),
    .AluIn(AluIn), .MemDataIn(MemDataIn), .MemAck(MemAck), .ResumeIn(ResumeIn),
    .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemDataOut(MemDataOut), .MainBus(MainBus), .Stall(Stall),
    .PcraFlip(PcraFlip), .Halted(Halted), .PcOut(PcOut), .SpOut(SpOut)
  );

  initial ClockIn = 1'b0;
  always #5 ClockIn = ~ClockIn;

  function automatic logic [15:0] mk(input int as, input int ld, input int inc,
                                     input int ad, input bit br, input bit fl,
                                     input bit bk);
    return {bk, fl, br, ad[2:0], inc[1:0], ld[3:0], as[3:0]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    m_pc[0] = 16'h0000;
    m_pc[1] = 16'h0000;
    m_sp    = 16'hFFFF;
    m_flip  = 1'b0;
    m_halt  = 1'b0;
  endtask

  function automatic logic [7:0] model_bus(input logic [3:0] src, input bit lvis,
                                           input logic [7:0] lv, input logic [7:0] c,
                                           input logic [7:0] alu);
    if (src >= 4'd1 && src <= 4'd4) return m_reg[src - 4'd1];
    if (src == 4'd5) return c;
    if (src == 4'd6) return lvis ? lv : 8'h00;
    if (src == 4'd7) return alu;
    return 8'h00;
  endfunction

  function automatic logic [15:0] model_addr(input logic [2:0] a);
    case (a)
      3'd0:    return m_pc[m_flip];
      3'd1:    return m_pc[!m_flip];
      3'd2:    return m_sp;
      3'd3:    return {m_reg[0], m_reg[1]};
      3'd4:    return {m_reg[2], m_reg[3]};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_commit(input logic [15:0] w, input logic [7:0] c,
                              input logic [7:0] alu, input bit lvis,
                              input logic [7:0] lv);
    logic [7:0]  bv;
    logic [3:0]  ld;
    logic [15:0] nxt;
    bv  = model_bus(w[3:0], lvis, lv, c, alu);
    ld  = w[7:4];
    nxt = m_pc[m_flip];
    if (w[9:8] == 2'd1) nxt = nxt + 16'd1;
    if (ld == 4'd6) nxt = {nxt[15:8], bv};
    if (ld == 4'd7) nxt = {bv, nxt[7:0]};
    if (ld >= 4'd1 && ld <= 4'd4) m_reg[ld - 4'd1] = bv;
    m_pc[m_flip] = nxt;
    if (w[9:8] == 2'd2) m_sp = m_sp + 16'd1;
    if (w[9:8] == 2'd3) m_sp = m_sp - 16'd1;
    if (w[14]) m_flip = !m_flip;
    if (w[15]) m_halt = 1'b1;
  endtask

  task automatic step();
    @(posedge ClockIn);
    #1;
  endtask

  // Reads A-D through the combinational bus with side-effect-free words.
  task automatic peek_regs(output logic [7:0] r0, output logic [7:0] r1,
                           output logic [7:0] r2, output logic [7:0] r3);
    CtrlIn = 16'h0001; #1 r0 = MainBus;
    CtrlIn = 16'h0002; #1 r1 = MainBus;
    CtrlIn = 16'h0003; #1 r2 = MainBus;
    CtrlIn = 16'h0004; #1 r3 = MainBus;
    CtrlIn = 16'h0000;
  endtask

  task automatic run_word(input logic [15:0] w, input logic [7:0] c,
                          input logic [7:0] alu);
    CtrlIn  = w;
    ConstIn = c;
    AluIn   = alu;
    #1 seen_stall = Stall;
    step();
    if (!m_halt) model_commit(w, c, alu, 1'b0, 8'h00);
    CtrlIn = 16'h0000;
  endtask

  task automatic test_reset();
    logic [7:0] r0, r1, r2, r3;
    ResetIn = 1'b1;
    #2;
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if ({r0, r1, r2, r3} !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got %h expected %h", {r0, r1, r2, r3}, 32'h0);
    end
    tests_run++;
    if ({PcOut, SpOut} !== {16'h0000, 16'hFFFF}) begin
      tests_failed++;
      $display("[TB] FAIL reset_pc_sp: got %h expected %h", {PcOut, SpOut}, 32'h0000FFFF);
    end
    tests_run++;
    if ({MemReq, MemWrite, MemAddr, MemDataOut, Stall, PcraFlip, Halted} !== 29'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %h expected %h",
               {MemReq, MemWrite, MemAddr, MemDataOut, Stall, PcraFlip, Halted}, 29'h0);
    end
    @(posedge ClockIn); #1;
    ResetIn = 1'b0;
    model_reset();
  endtask

  task automatic test_const_load();
    logic [7:0] r0, r1, r2, r3;
    run_word(mk(5, 1, 0, 0, 0, 0, 0), 8'h5A, 8'h00);
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if (r0 !== 8'h5A) begin
      tests_failed++;
      $display("[TB] FAIL const_load_a: got %h expected %h", r0, 8'h5A);
    end
    tests_run++;
    if ({seen_stall, MemReq} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL const_load_stall_req: got %b expected %b", {seen_stall, MemReq}, 2'b00);
    end
  endtask

  task automatic test_pc_sp_wrap();
    run_word(mk(5, 6, 0, 0, 0, 0, 0), 8'hFF, 8'h00);
    run_word(mk(5, 7, 0, 0, 0, 0, 0), 8'hFF, 8'h00);
    tests_run++;
    if (PcOut !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL pc_byte_load: got %h expected %h", PcOut, 16'hFFFF);
    end
    run_word(mk(0, 0, 1, 0, 0, 0, 0), 8'h00, 8'h00);
    tests_run++;
    if (PcOut !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL pc_inc_wrap: got %h expected %h", PcOut, 16'h0000);
    end
    run_word(mk(0, 0, 3, 0, 0, 0, 0), 8'h00, 8'h00);
    tests_run++;
    if (SpOut !== 16'hFFFE) begin
      tests_failed++;
      $display("[TB] FAIL sp_dec: got %h expected %h", SpOut, 16'hFFFE);
    end
    run_word(mk(0, 0, 2, 0, 0, 0, 0), 8'h00, 8'h00);
    run_word(mk(0, 0, 2, 0, 0, 0, 0), 8'h00, 8'h00);
    tests_run++;
    if (SpOut !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL sp_inc_wrap: got %h expected %h", SpOut, 16'h0000);
    end
    run_word(mk(0, 0, 3, 0, 0, 0, 0), 8'h00, 8'h00);
    tests_run++;
    if (SpOut !== 16'hFFFF) begin
      tests_failed++;
      $display("[TB] FAIL sp_dec_wrap: got %h expected %h", SpOut, 16'hFFFF);
    end
    // Inc with a high-byte load: low half comes from the increment.
    run_word(mk(5, 7, 1, 0, 0, 0, 0), 8'hAB, 8'h00);
    tests_run++;
    if (PcOut !== 16'hAB01) begin
      tests_failed++;
      $display("[TB] FAIL pc_inc_with_load: got %h expected %h", PcOut, 16'hAB01);
    end
  endtask

  task automatic test_read();
    logic [15:0] w;
    logic [7:0]  r0, r1, r2, r3;
    run_word(mk(5, 6, 0, 0, 0, 0, 0), 8'h34, 8'h00);
    run_word(mk(5, 7, 0, 0, 0, 0, 0), 8'h12, 8'h00);
    w = mk(6, 2, 0, 0, 1, 0, 0);
    CtrlIn = w;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL read_idle_stall: got %b expected %b", Stall, 1'b1);
    end
    step();
    tests_run++;
    if ({MemReq, MemWrite, MemAddr, Stall} !== {1'b1, 1'b0, 16'h1234, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL read_req1: got %h expected %h",
               {MemReq, MemWrite, MemAddr, Stall}, {1'b1, 1'b0, 16'h1234, 1'b1});
    end
    step();
    tests_run++;
    if ({MemReq, Stall} !== 2'b11) begin
      tests_failed++;
      $display("[TB] FAIL read_req2: got %b expected %b", {MemReq, Stall}, 2'b11);
    end
    MemAck    = 1'b1;
    MemDataIn = 8'hC3;
    step();
    MemAck = 1'b0;
    tests_run++;
    if ({MemReq, Stall, MainBus} !== {1'b0, 1'b0, 8'hC3}) begin
      tests_failed++;
      $display("[TB] FAIL read_done: got %h expected %h", {MemReq, Stall, MainBus}, {1'b0, 1'b0, 8'hC3});
    end
    model_commit(w, 8'h00, 8'h00, 1'b1, 8'hC3);
    step();
    CtrlIn = 16'h0000;
    // Stray acknowledge in IDLE must not start anything.
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    tests_run++;
    if ({MemReq, PcOut} !== {1'b0, 16'h1234}) begin
      tests_failed++;
      $display("[TB] FAIL read_after: got %h expected %h", {MemReq, PcOut}, {1'b0, 16'h1234});
    end
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if (r1 !== 8'hC3) begin
      tests_failed++;
      $display("[TB] FAIL read_b: got %h expected %h", r1, 8'hC3);
    end
  endtask

  task automatic test_write();
    logic [15:0] w;
    int          held_bad;
    run_word(mk(5, 1, 0, 0, 0, 0, 0), 8'h11, 8'h00);
    run_word(mk(5, 2, 0, 0, 0, 0, 0), 8'h22, 8'h00);
    run_word(mk(5, 3, 0, 0, 0, 0, 0), 8'h77, 8'h00);
    w = mk(3, 5, 0, 3, 1, 0, 0);
    CtrlIn = w;
    step();
    held_bad = 0;
    for (int i = 0; i < 3; i++) begin
      if ({MemReq, MemWrite, MemAddr, MemDataOut, Stall} !== {1'b1, 1'b1, 16'h1122, 8'h77, 1'b1})
        held_bad++;
      step();
    end
    tests_run++;
    if (held_bad !== 0) begin
      tests_failed++;
      $display("[TB] FAIL write_held: got %0d bad cycles expected %0d (last %h)", held_bad, 0,
               {MemReq, MemWrite, MemAddr, MemDataOut});
    end
    MemAck = 1'b1;
    step();
    MemAck = 1'b0;
    tests_run++;
    if ({MemReq, Stall} !== 2'b00) begin
      tests_failed++;
      $display("[TB] FAIL write_done: got %b expected %b", {MemReq, Stall}, 2'b00);
    end
    model_commit(w, 8'h00, 8'h00, 1'b1, 8'h00);
    step();
    CtrlIn = 16'h0000;
  endtask

  task automatic test_flip_break();
    logic [7:0]  r0, r1, r2, r3;
    logic [15:0] wa;
    run_word(mk(5, 6, 0, 0, 0, 0, 0), 8'h10, 8'h00);
    run_word(mk(5, 7, 0, 0, 0, 0, 0), 8'h00, 8'h00);
    run_word(mk(0, 0, 0, 0, 0, 1, 0), 8'h00, 8'h00);
    run_word(mk(5, 6, 0, 0, 0, 0, 0), 8'h00, 8'h00);
    run_word(mk(5, 7, 0, 0, 0, 0, 0), 8'h02, 8'h00);
    run_word(mk(0, 0, 0, 0, 0, 1, 0), 8'h00, 8'h00);
    tests_run++;
    if (PcOut !== 16'h0010) begin
      tests_failed++;
      $display("[TB] FAIL flip_setup_pc: got %h expected %h", PcOut, 16'h0010);
    end
    run_word(mk(0, 0, 1, 0, 0, 1, 1), 8'h00, 8'h00);
    tests_run++;
    if ({Halted, PcraFlip, PcOut} !== {1'b1, 1'b1, 16'h0200}) begin
      tests_failed++;
      $display("[TB] FAIL break_commit: got %h expected %h", {Halted, PcraFlip, PcOut}, {1'b1, 1'b1, 16'h0200});
    end
    peek_regs(r0, r1, r2, r3);
    wa = mk(5, 1, 0, 0, 0, 0, 0);
    CtrlIn  = wa;
    ConstIn = 8'h3C;
    #1;
    tests_run++;
    if (Stall !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL halted_stall: got %b expected %b", Stall, 1'b1);
    end
    step();
    step();
    ResumeIn = 1'b1;
    step();
    ResumeIn = 1'b0;
    m_halt = 1'b0;
    tests_run++;
    if (Halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL resume_clear: got %b expected %b", Halted, 1'b0);
    end
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if (r0 !== m_reg[0]) begin
      tests_failed++;
      $display("[TB] FAIL halted_no_commit: got %h expected %h", r0, m_reg[0]);
    end
    CtrlIn = wa;
    step();
    model_commit(wa, 8'h3C, 8'h00, 1'b0, 8'h00);
    CtrlIn = 16'h0000;
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if (r0 !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL resume_commit: got %h expected %h", r0, 8'h3C);
    end
    run_word(mk(0, 0, 0, 0, 0, 1, 0), 8'h00, 8'h00);
    tests_run++;
    if ({PcraFlip, PcOut} !== {1'b0, 16'h0011}) begin
      tests_failed++;
      $display("[TB] FAIL break_pc_inc: got %h expected %h", {PcraFlip, PcOut}, {1'b0, 16'h0011});
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    logic [7:0]  c, alu, rd, exp_wd;
    logic [15:0] exp_addr;
    logic        exp_wr;
    logic [7:0]  r0, r1, r2, r3;
    int          dly;
    for (int n = 0; n < 40; n++) begin
      w = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
             $urandom_range(0, 7), ($urandom_range(0, 2) == 0), $urandom_range(0, 1), 1'b0);
      c   = 8'($urandom);
      alu = 8'($urandom);
      if (!w[13]) begin
        MemAck = 1'($urandom_range(0, 1));
        run_word(w, c, alu);
        MemAck = 1'b0;
        tests_run++;
        if ({seen_stall, MemReq} !== 2'b00) begin
          tests_failed++;
          $display("[TB] FAIL rnd_plain_stall: word %h got %b expected %b", w, {seen_stall, MemReq}, 2'b00);
        end
      end else begin
        exp_addr = model_addr(w[12:10]);
        exp_wr   = (w[7:4] == 4'd5);
        exp_wd   = model_bus(w[3:0], 1'b0, 8'h00, c, alu);
        CtrlIn  = w;
        ConstIn = c;
        AluIn   = alu;
        step();
        tests_run++;
        if ({MemReq, MemWrite, MemAddr, MemDataOut, Stall} !== {1'b1, exp_wr, exp_addr, exp_wd, 1'b1}) begin
          tests_failed++;
          $display("[TB] FAIL rnd_bus_req: word %h got %h expected %h", w,
                   {MemReq, MemWrite, MemAddr, MemDataOut, Stall}, {1'b1, exp_wr, exp_addr, exp_wd, 1'b1});
        end
        dly = $urandom_range(0, 2);
        for (int k = 0; k < dly; k++) step();
        rd        = 8'($urandom);
        MemAck    = 1'b1;
        MemDataIn = rd;
        step();
        MemAck = 1'b0;
        tests_run++;
        if ({MemReq, Stall} !== 2'b00) begin
          tests_failed++;
          $display("[TB] FAIL rnd_bus_done: word %h got %b expected %b", w, {MemReq, Stall}, 2'b00);
        end
        model_commit(w, c, alu, 1'b1, rd);
        step();
        CtrlIn = 16'h0000;
      end
      peek_regs(r0, r1, r2, r3);
      tests_run++;
      if ({r0, r1, r2, r3, PcOut, SpOut, PcraFlip, Halted} !==
          {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_pc[m_flip], m_sp, m_flip, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL rnd_state: word %h got %h expected %h", w,
                 {r0, r1, r2, r3, PcOut, SpOut, PcraFlip, Halted},
                 {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_pc[m_flip], m_sp, m_flip, 1'b0});
      end
    end
  endtask

  task automatic test_reset_mid_req();
    logic [7:0] r0, r1, r2, r3;
    run_word(mk(5, 1, 0, 0, 0, 0, 0), 8'h99, 8'h00);
    run_word(mk(0, 0, 3, 0, 0, 1, 0), 8'h00, 8'h00);
    CtrlIn = mk(1, 0, 0, 2, 1, 0, 0);
    step();
    tests_run++;
    if (MemReq !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL midreq_launch: got %b expected %b", MemReq, 1'b1);
    end
    ResetIn = 1'b1;
    #1;
    tests_run++;
    if ({MemReq, PcOut, SpOut, PcraFlip} !== {1'b0, 16'h0000, 16'hFFFF, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL midreq_reset: got %h expected %h", {MemReq, PcOut, SpOut, PcraFlip},
               {1'b0, 16'h0000, 16'hFFFF, 1'b0});
    end
    CtrlIn = 16'h0000;
    peek_regs(r0, r1, r2, r3);
    tests_run++;
    if ({r0, r1, r2, r3} !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL midreq_regs: got %h expected %h", {r0, r1, r2, r3}, 32'h0);
    end
    model_reset();
    ResetIn   = 1'b0;
    MemAck    = 1'b1;
    MemDataIn = 8'hEE;
    step();
    step();
    MemAck = 1'b0;
    tests_run++;
    if ({MemReq, Stall, PcOut, SpOut} !== {1'b0, 1'b0, 16'h0000, 16'hFFFF}) begin
      tests_failed++;
      $display("[TB] FAIL midreq_late_ack: got %h expected %h", {MemReq, Stall, PcOut, SpOut},
               {1'b0, 1'b0, 16'h0000, 16'hFFFF});
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    CtrlIn    = 16'h0000;
    ConstIn   = 8'h00;
    AluIn     = 8'h00;
    MemDataIn = 8'h00;
    MemAck    = 1'b0;
    ResumeIn  = 1'b0;
    ResetIn   = 1'b0;
    model_reset();
    test_reset();
    test_const_load();
    test_pc_sp_wrap();
    test_read();
    test_write();
    test_flip_break();
    test_random();
    test_reset_mid_req();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/main_bus_unit.md
Name: main_bus_unit

Overview:
- Execution-side consumer of the 16-line Pipeline Stage 2 control word; performs the micro-op the word encodes.
- Owns general registers A–D, the 16-bit program counter pair PC/RA, and SP.
- Drives the 8-bit main bus, runs the memory bus-request handshake, stalls the pipeline while memory is busy, and produces the PCRA-flip and halt state that feed back into the Flags inputs.

Parameters:
- ADDR_W, 16, memory address width; PC, RA and SP width.
- DATA_W, 8, main bus and register width.

Ports:
- ClockIn  in  1  system clock, rising edge.
- ResetIn  in  1  asynchronous, active-high reset.
- CtrlIn  in  16  Stage 2 control word. Bit map: [3:0] MainAssert, [7:4] MainLoad, [9:8] Inc, [12:10] Addr, [13] BusRequest, [14] PCRA_Flip, [15] Break.
- ConstIn  in  8  immediate byte from the pipeline.
- AluIn  in  8  ALU result.
- MemDataIn  in  8  memory read data, valid when MemAck=1.
- MemAck  in  1  memory completion strobe.
- ResumeIn  in  1  clears halt.
- MemReq  out  1  memory request, registered.
- MemWrite  out  1  1 = write cycle, registered.
- MemAddr  out  16  registered address.
- MemDataOut  out  8  registered write data.
- MainBus  out  8  current bus value, combinational.
- Stall  out  1  upstream must hold CtrlIn, ConstIn and AluIn stable.
- PcraFlip  out  1  flip state; feeds Flags_5.
- Halted  out  1  halt state.
- PcOut  out  16  active program counter.
- SpOut  out  16  stack pointer.

Behaviour:
- Reset (async, immediate): A–D=0x00, PC=RA=0x0000, SP=0xFFFF, PcraFlip=0, Halted=0, FSM=IDLE. MemReq, MemWrite, MemAddr and MemDataOut all 0; Stall=0.
- Active PC = (PcraFlip ? RA : PC). "Inactive" is the other register.
- MainAssert source for MainBus:
  - 0: 0x00
  - 1–4: A–D
  - 5: ConstIn
  - 6: read latch (0x00 outside DONE)
  - 7: AluIn
  - 8–15: 0x00
- MainLoad destination:
  - 0: none
  - 1–4: A–D
  - 5: memory write (only meaningful when BusRequest=1; ignored otherwise)
  - 6: active PC[7:0]
  - 7: active PC[15:8]
  - 8–15: none
- Inc: 0 none; 1 active PC+1; 2 SP+1; 3 SP−1. All modulo 2^16, so 0xFFFF+1=0x0000 and 0x0000−1=0xFFFF.
- Inc combined with MainLoad 6 or 7 in the same word: the loaded byte wins for that half; the Inc result supplies the other half.
- Addr: 0 active PC; 1 inactive PC; 2 SP; 3 {A,B}; 4 {C,D}; 5–7 → 0x0000.
- Commit: all register loads, Inc, flip toggle and Break take effect on a single commit edge. Values sampled at commit are pre-commit state, so the address uses the pre-flip and pre-Inc values.
- Non-bus word (BusRequest=0), not halted: commits on the next rising edge. Stall=0. Latency 1.
- FSM for BusRequest=1:
  - IDLE: Stall=1 combinationally. At the next edge, register MemAddr from Addr, MemWrite=(MainLoad==5), MemDataOut=MainBus and MemReq=1, then go to REQ.
  - REQ: MemReq, MemAddr, MemWrite and MemDataOut held; Stall=1. On an edge with MemAck=1: capture MemDataIn into the read latch, drop MemReq, go to DONE. No timeout.
  - DONE: Stall=0. The word commits at this edge; the read latch is visible as MainAssert 6. Return to IDLE.
  - Minimum bus-word latency: 3 edges.
- MemAck outside REQ is ignored.
- Halt:
  - A committed word with Break=1 commits its other actions and sets Halted at the same edge.
  - While Halted: no commits, no new requests, Stall=1.
  - ResumeIn=1 clears Halted at the next edge; the word presented commits at the following edge.
  - ResumeIn while not halted: ignored.
- Reset during REQ: MemReq drops asynchronously; the in-flight transfer is abandoned.
- MainLoad target equal to MainAssert source reloads the same value (no change).

Test Plan:
- Reset release; CtrlIn MainAssert=5, MainLoad=1, ConstIn=0x5A → A=0x5A after 1 edge; Stall stays 0; MemReq stays 0.
- Load PC low=0xFF and PC high=0xFF, then word Inc=1 → PcOut=0x0000 (wrap). Then Inc=3 on SP from reset → SpOut=0xFFFE.
- Read: PC=0x1234, Addr=0, BusRequest=1, MainAssert=6, MainLoad=2. MemAck after 2 REQ cycles with MemDataIn=0xC3 → MemAddr=0x1234, MemWrite=0, MemReq high exactly until the ack edge, B=0xC3 at the DONE edge, Stall low only in DONE.
- Write: A=0x11, B=0x22, C=0x77; Addr=3, MainAssert=3, MainLoad=5, BusRequest=1 → MemAddr=0x1122, MemWrite=1, MemDataOut=0x77 held until MemAck.
- Flip + Break: PC=0x0010, RA=0x0200; word PCRA_Flip=1, Break=1, Inc=1 → PC=0x0011, PcraFlip=1, PcOut=0x0200, Halted=1. Next word ignored until ResumeIn pulse; that word commits 2 edges after ResumeIn.
- Assert ResetIn mid-REQ (MemReq=1) → MemReq=0 before the next clock edge; all registers at reset values; MemAck arriving after reset has no effect.
